lcd_nibble_writer: RTL and testbench

Byte-to-nibble bus engine for an HD44780-compatible character LCD in 4-bit mode. It sits between the `lcd` sequencer, which decides what bytes to send, and the LCD pins (RS, E, D4–D7). It accepts one byte or init nibble per valid/ready handshake and drives the nibble(s) with the required setup, enable-pulse and gap timing. It then enforces the controller's post-write execution delay before accepting the next transfer.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_delay_cnt.sv | 23 ++
 rtl/lcd_nibble_writer.sv | 97 +++++++++
 tb/tb_lcd_nibble_writer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, HD44780 command/init constants and wait-class helper
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_H,
        EHIGH_H,
        GAP,
        SETUP_L,
        EHIGH_L,
        WAIT
    } lcd_state_t;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;
    localparam logic [3:0] LCD_INIT8 = 4'h3;
    localparam logic [3:0] LCD_INIT4 = 4'h2;

    // clear, home (0x02 and its 0x03 alias) and init nibbles need the long execution delay
    function automatic logic lcd_long_wait(input logic [7:0] din, input logic rs, input logic nib);
        return nib || (!rs && (din == LCD_CLEAR || din == LCD_HOME || din == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter that stops at zero and flags it
module lcd_delay_cnt #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (!zero)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: splits a byte (or sends one init nibble) onto an HD44780
// 4-bit bus with setup/E-pulse/gap timing and a post-write execution delay.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 1,
    parameter int E_HIGH_CYC    = 2,
    parameter int GAP_CYC       = 2,
    parameter int CMD_WAIT_CYC  = 40,
    parameter int LONG_WAIT_CYC = 1640
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DIN,
    input  logic       DIN_RS,
    input  logic       DIN_NIB,
    input  logic       VALID,
    output logic       READY,
    output logic       RS,
    output logic       E,
    output logic [3:0] D
);
    localparam int CW = $clog2(LONG_WAIT_CYC + 1);
    localparam logic [CW-1:0] SETUP_V = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EHIGH_V = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] GAP_V   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CMD_V   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] LONG_V  = CW'(LONG_WAIT_CYC - 1);

    lcd_state_t    state, next;
    logic          load, zero, accept, nib_q, long_q;
    logic [CW-1:0] load_val, wait_v;
    logic [3:0]    din_lo;

    assign READY  = (state == IDLE);
    assign accept = READY && VALID;
    assign wait_v = long_q ? LONG_V : CMD_V;

    lcd_delay_cnt #(.W(CW)) u_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .load  (load),
        .value (load_val),
        .zero  (zero)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= next;
    end

    // every transition reloads the shared counter with the new state's length minus one
    always_comb begin
        next     = state;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE:    if (VALID) begin next = SETUP_H; load = 1'b1; load_val = SETUP_V; end
            SETUP_H: if (zero)  begin next = EHIGH_H; load = 1'b1; load_val = EHIGH_V; end
            EHIGH_H: if (zero)  begin
                next     = nib_q ? WAIT : GAP;
                load     = 1'b1;
                load_val = nib_q ? wait_v : GAP_V;
            end
            GAP:     if (zero)  begin next = SETUP_L; load = 1'b1; load_val = SETUP_V; end
            SETUP_L: if (zero)  begin next = EHIGH_L; load = 1'b1; load_val = EHIGH_V; end
            EHIGH_L: if (zero)  begin next = WAIT;    load = 1'b1; load_val = wait_v;  end
            WAIT:    if (zero)  next = IDLE;
            default: next = IDLE;
        endcase
    end

    // D changes only on SETUP_L entry, so it is never updated on an E falling edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            E      <= 1'b0;
            RS     <= 1'b0;
            D      <= 4'h0;
            din_lo <= 4'h0;
            nib_q  <= 1'b0;
            long_q <= 1'b0;
        end else begin
            E <= (next == EHIGH_H) || (next == EHIGH_L);
            if (accept) begin
                RS     <= DIN_RS;
                D      <= DIN[7:4];
                din_lo <= DIN[3:0];
                nib_q  <= DIN_NIB;
                long_q <= lcd_long_wait(DIN, DIN_RS, DIN_NIB);
            end else if (state == GAP && next == SETUP_L) begin
                D <= din_lo;
            end
        end
    end
endmodule

// File: tb/tb_lcd_nibble_writer.sv
// tb_lcd_nibble_writer: scoreboard bench; expected E-pulse nibbles and busy
// lengths are queued when a transfer is driven and popped as the bus shows them.
module tb_lcd_nibble_writer;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       DIN_RS = 1'b0;
    logic       DIN_NIB = 1'b0;
    logic       VALID = 1'b0;
    logic       READY, RS, E;
    logic [3:0] D;

    int checks = 0;
    int failures = 0;
    logic [4:0] pq[$];
    int         bq[$];
    logic       e_prev = 1'b0;
    logic [4:0] cur = '0;
    int         e_w = 0;
    int         busy = 0;
    int         npulse = 0;

    lcd_nibble_writer dut (
        .CLK     (CLK),
        .RST     (RST),
        .DIN     (DIN),
        .DIN_RS  (DIN_RS),
        .DIN_NIB (DIN_NIB),
        .VALID   (VALID),
        .READY   (READY),
        .RS      (RS),
        .E       (E),
        .D       (D)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int busy_len(input logic [7:0] b, input logic rs, input logic nib);
        if (nib) return 1 + 2 + 1640;
        if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return 8 + 1640;
        return 8 + 40;
    endfunction

    task automatic push(input logic [7:0] b, input logic rs, input logic nib);
        pq.push_back({rs, b[7:4]});
        if (!nib) pq.push_back({rs, b[3:0]});
        bq.push_back(busy_len(b, rs, nib));
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!READY && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        if (!READY) check("ready_timeout", 32'(READY), 1);
    endtask

    task automatic send(input logic [7:0] b, input logic rs, input logic nib);
        wait_ready();
        DIN = b; DIN_RS = rs; DIN_NIB = nib; VALID = 1'b1;
        push(b, rs, nib);
        @(posedge CLK);
        #1 VALID = 1'b0;
    endtask

    // bus monitor: pulse content, data stability through and after E, pulse width, busy length
    always @(negedge CLK) begin
        if (!RST) begin
            e_prev = 1'b0;
            busy = 0;
        end else begin
            if (E && !e_prev) begin
                npulse++;
                cur = {RS, D};
                e_w = 1;
                if (pq.size() == 0) check("unexpected_pulse", {27'd0, cur}, 32'h1ff);
                else check("pulse_rs_d", {27'd0, cur}, {27'd0, pq.pop_front()});
            end else if (E) begin
                e_w++;
                check("held_in_e", {27'd0, RS, D}, {27'd0, cur});
            end else if (e_prev) begin
                check("e_width", e_w, 2);
                check("held_after_fall", {27'd0, RS, D}, {27'd0, cur});
            end
            if (!READY) busy++;
            else if (busy != 0) begin
                if (bq.size() == 0) check("unexpected_busy", busy, 0);
                else check("busy_len", busy, bq.pop_front());
                busy = 0;
            end
            e_prev = E;
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_e", 32'(E), 0);
        check("idle_rs", 32'(RS), 0);
        check("idle_d", 32'(D), 0);
        check("idle_ready", 32'(READY), 1);
        check("idle_no_pulse", npulse, 0);

        send(8'h48, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        send(8'h28, 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b1);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0);

        // VALID held with DIN churning while busy
        wait_ready();
        @(negedge CLK);
        DIN = 8'h41; DIN_RS = 1'b1; DIN_NIB = 1'b0; VALID = 1'b1;
        push(8'h41, 1'b1, 1'b0);
        @(posedge CLK);
        #1 DIN = 8'h5A;
        repeat (10) @(negedge CLK);
        DIN = 8'h42;
        push(8'h42, 1'b1, 1'b0);
        wait_ready();
        @(negedge CLK);
        check("b2b_no_bubble", 32'(READY), 0);
        VALID = 1'b0;

        // reset during the second E pulse
        send(8'h48, 1'b1, 1'b0);
        repeat (6) @(posedge CLK);
        #1 check("e_before_rst", 32'(E), 1);
        RST = 1'b0;
        #1;
        check("rst_e", 32'(E), 0);
        check("rst_rs", 32'(RS), 0);
        check("rst_d", 32'(D), 0);
        pq.delete();
        bq.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        send(8'h6C, 1'b1, 1'b0);

        begin
            int t = 0;
            while (bq.size() != 0 && t < 5000) begin
                @(negedge CLK);
                t++;
            end
        end
        check("pulses_left", pq.size(), 0);
        check("busy_left", bq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
